addsub_arbiter: RTL and testbench
=================================

// Module: addsub_arbiter
// PURPOSE
//  Shares one saturating WIDTH-bit add/sub unit (cla_16bit) between two requesters.
//  Performs round-robin or fixed-priority arbitration, valid/ready request
//  handshakes and per-requester response handshakes.
//  Drives the unit operands and registers its result.
//  Sits between the ALU-side requester (port 0) and the address/branch-side requester (port 1).
// PARAMETERS
//  WIDTH     16  operand/result width; must match the shared unit
//  RR_EN     1   1 = round-robin grant; 0 = fixed priority, port 0 wins
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      synchronous, active-low reset
//  reqN_valid   in   1      N=0,1: request present
//  reqN_a       in   WIDTH  N=0,1: operand A
//  reqN_b       in   WIDTH  N=0,1: operand B
//  reqN_sub     in   1      N=0,1: 1 = A-B, 0 = A+B
//  reqN_ready   out  1      N=0,1: request accepted when valid&ready
//  rspN_valid   out  1      N=0,1: result available
//  rspN_data    out  WIDTH  N=0,1: saturated result
//  rspN_ovfl    out  1      N=0,1: saturation occurred
//  rspN_ready   in   1      N=0,1: consumer takes response
//  au_a         out  WIDTH  to shared unit: operand a
//  au_b         out  WIDTH  to shared unit: operand b
//  au_sub       out  1      to shared unit: sub
//  au_sum       in   WIDTH  from shared unit: sum (combinational)
//  au_ovfl      in   1      from shared unit: overflow flag (combinational)
// BEHAVIOUR
//  FSM states: IDLE, EXEC, RESP. Reset (rst_n=0 at posedge) -> IDLE:
//   all reqN_ready=0, rspN_valid=0, rspN_data=0, rspN_ovfl=0.
//   au_a=0, au_b=0, au_sub=0. Priority pointer = port 0.
//  IDLE: reqN_ready is combinational. At most one is high per cycle; never ready in EXEC/RESP.
//   Grant rule when both valid: RR_EN=1 -> pointer port; RR_EN=0 -> port 0.
//   Grant rule when one valid: that port.
//   On handshake, latch a/b/sub/port into operand regs -> EXEC. No valid -> stay IDLE.
//   Pointer moves to the other port after every grant (RR_EN=1 only).
//  EXEC (exactly 1 cycle): au_* driven from operand regs.
//   au_sum/au_ovfl captured into the granted port's rsp regs at cycle end -> RESP.
//   au_* hold last operands outside EXEC; never X.
//  RESP: granted rspN_valid=1; data/ovfl stable while valid.
//   rspN_ready=1 -> valid drops next cycle -> IDLE.
//   Otherwise hold RESP (backpressure); no new grants.
//  Latency: handshake in cycle T -> rsp_valid rises in T+2.
//   Minimum issue interval is 3 cycles with rsp_ready tied high.
//  Results are saturated two's complement from the unit:
//   add overflow -> 0x7FFF, ovfl=1; negative overflow -> 0x8000, ovfl=1.
//   The arbiter does not re-saturate; it passes data and flag through.
//  Only the granted port's rsp signals change; the other port's remain 0/held.
//  Request with valid deasserted mid-IDLE: no grant; requesters must hold valid/operands until ready.
//  Reset asserted in EXEC or RESP: pending transaction dropped, no response, outputs at reset values next cycle.
//  rspN_ready while rspN_valid=0 is ignored.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with both valid=1 -> all ready/valid=0; first grant to port 0 after release.
//  2 Add: port0 a=0x0003 b=0x0004 sub=0 -> rsp0_valid at T+2, data=0x0007, ovfl=0.
//  3 Saturation: port1 a=0x7000 b=0x2000 add -> data=0x7FFF, ovfl=1.
//    port1 a=0x8000 b=0x0001 sub -> data=0x8000, ovfl=1.
//  4 Contention: both valid continuously, RR_EN=1, rsp_ready=1 -> grants alternate 0,1,0,1; each issue 3 cycles apart.
//    Same stimulus with RR_EN=0 -> port 0 granted every time.
//  5 Backpressure: rsp0_ready=0 for 5 cycles -> rsp0_valid/data stable, req1_ready=0 throughout; port1 granted after release.
//  6 Mid-op reset: rst_n=0 during EXEC -> no rsp_valid ever for that request; FSM in IDLE next cycle.

Source files
------------

// File: rtl/addsub_arbiter.sv
// Two-port arbiter in front of one shared saturating add/sub unit.
// It handles the request/response handshakes and registers the unit's result for the granted port.
module addsub_arbiter #(
   parameter int WIDTH = 16,
   parameter bit RR_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sub,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sub,
   output logic             req1_ready,
   output logic             rsp0_valid,
   output logic [WIDTH-1:0] rsp0_data,
   output logic             rsp0_ovfl,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   output logic [WIDTH-1:0] rsp1_data,
   output logic             rsp1_ovfl,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] au_a,
   output logic [WIDTH-1:0] au_b,
   output logic             au_sub,
   input  logic [WIDTH-1:0] au_sum,
   input  logic             au_ovfl
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             port_q, port_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic             op_sub_q, op_sub_d;
   logic             rsp0_valid_q, rsp0_valid_d;
   logic [WIDTH-1:0] rsp0_data_q, rsp0_data_d;
   logic             rsp0_ovfl_q, rsp0_ovfl_d;
   logic             rsp1_valid_q, rsp1_valid_d;
   logic [WIDTH-1:0] rsp1_data_q, rsp1_data_d;
   logic             rsp1_ovfl_q, rsp1_ovfl_d;
   logic             gnt0_s, gnt1_s;

   // Port 1 wins only when alone or when round-robin points at it.
   always_comb begin
      gnt1_s = req1_valid & (~req0_valid | (RR_EN & ptr_q));
      gnt0_s = req0_valid & ~gnt1_s;
   end

   assign req0_ready = rst_n & (state_q == IDLE) & gnt0_s;
   assign req1_ready = rst_n & (state_q == IDLE) & gnt1_s;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      port_d       = port_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      op_sub_d     = op_sub_q;
      rsp0_valid_d = rsp0_valid_q;
      rsp0_data_d  = rsp0_data_q;
      rsp0_ovfl_d  = rsp0_ovfl_q;
      rsp1_valid_d = rsp1_valid_q;
      rsp1_data_d  = rsp1_data_q;
      rsp1_ovfl_d  = rsp1_ovfl_q;
      case (state_q)
         IDLE: begin
            if (req0_ready | req1_ready) begin
               port_d   = req1_ready;
               op_a_d   = req1_ready ? req1_a : req0_a;
               op_b_d   = req1_ready ? req1_b : req0_b;
               op_sub_d = req1_ready ? req1_sub : req0_sub;
               ptr_d    = RR_EN ? ~ptr_q : ptr_q;
               state_d  = EXEC;
            end else begin
               state_d  = IDLE;
            end
         end
         EXEC: begin
            if (port_q) begin
               rsp1_valid_d = 1'b1;
               rsp1_data_d  = au_sum;
               rsp1_ovfl_d  = au_ovfl;
            end else begin
               rsp0_valid_d = 1'b1;
               rsp0_data_d  = au_sum;
               rsp0_ovfl_d  = au_ovfl;
            end
            state_d = RESP;
         end
         RESP: begin
            // Data and flag are held after valid drops; only valid is cleared.
            if (port_q ? rsp1_ready : rsp0_ready) begin
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
               state_d      = IDLE;
            end else begin
               state_d      = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ptr_q        <= 1'b0;
         port_q       <= 1'b0;
         op_a_q       <= {WIDTH{1'b0}};
         op_b_q       <= {WIDTH{1'b0}};
         op_sub_q     <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp0_data_q  <= {WIDTH{1'b0}};
         rsp0_ovfl_q  <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp1_data_q  <= {WIDTH{1'b0}};
         rsp1_ovfl_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         port_q       <= port_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_sub_q     <= op_sub_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp0_data_q  <= rsp0_data_d;
         rsp0_ovfl_q  <= rsp0_ovfl_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp1_data_q  <= rsp1_data_d;
         rsp1_ovfl_q  <= rsp1_ovfl_d;
      end
   end

   assign au_a       = op_a_q;
   assign au_b       = op_b_q;
   assign au_sub     = op_sub_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp0_data  = rsp0_data_q;
   assign rsp0_ovfl  = rsp0_ovfl_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp1_data  = rsp1_data_q;
   assign rsp1_ovfl  = rsp1_ovfl_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: instance 0 is round-robin, instance 1 fixed priority.
// Both share the same request stimulus, and each drives its own model of the saturating unit.
module tb_addsub_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   logic [1:0]        req_valid, req_sub, rsp_ready;
   logic [1:0][15:0]  req_a, req_b;
   logic [1:0][1:0]   ready_w, valid_w, ovfl_w;
   logic [1:0][1:0][15:0] data_w;
   logic [1:0][15:0]  au_a_w, au_b_w, au_sum_w;
   logic [1:0]        au_sub_w, au_ovfl_w;
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [16:0] sat_unit(input logic [15:0] a, input logic [15:0] b,
                                            input logic sub);
      logic [15:0] bb, r;
      logic        v;
      bb = sub ? ~b : b;
      r  = a + bb + {15'd0, sub};
      v  = (a[15] == bb[15]) && (r[15] != a[15]);
      return v ? {1'b1, (a[15] ? 16'h8000 : 16'h7FFF)} : {1'b0, r};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      assign {au_ovfl_w[g], au_sum_w[g]} = sat_unit(au_a_w[g], au_b_w[g], au_sub_w[g]);
      addsub_arbiter #(.WIDTH(16), .RR_EN((g == 0) ? 1'b1 : 1'b0)) dut (
         .clk(clk), .rst_n(rst_n),
         .req0_valid(req_valid[0]), .req0_a(req_a[0]), .req0_b(req_b[0]),
         .req0_sub(req_sub[0]), .req0_ready(ready_w[g][0]),
         .req1_valid(req_valid[1]), .req1_a(req_a[1]), .req1_b(req_b[1]),
         .req1_sub(req_sub[1]), .req1_ready(ready_w[g][1]),
         .rsp0_valid(valid_w[g][0]), .rsp0_data(data_w[g][0]), .rsp0_ovfl(ovfl_w[g][0]),
         .rsp0_ready(rsp_ready[0]),
         .rsp1_valid(valid_w[g][1]), .rsp1_data(data_w[g][1]), .rsp1_ovfl(ovfl_w[g][1]),
         .rsp1_ready(rsp_ready[1]),
         .au_a(au_a_w[g]), .au_b(au_b_w[g]), .au_sub(au_sub_w[g]),
         .au_sum(au_sum_w[g]), .au_ovfl(au_ovfl_w[g])
      );
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single-port request while idle, checking grant, latency and the response.
   task automatic do_req(input int p, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic [15:0] ed, input logic eo, input string tag);
      req_a[p] = a; req_b[p] = b; req_sub[p] = sub; req_valid[p] = 1'b1;
      #1;
      for (int g = 0; g < 2; g++) begin
         check_vec({tag, "_ready"}, ready_w[g][p], 1);
         check_vec({tag, "_other_ready"}, ready_w[g][1-p], 0);
      end
      step();
      req_valid[p] = 1'b0;
      for (int g = 0; g < 2; g++) check_vec({tag, "_t1_valid"}, valid_w[g][p], 0);
      step();
      for (int g = 0; g < 2; g++) begin
         check_vec({tag, "_t2_valid"}, valid_w[g][p], 1);
         check_vec({tag, "_data"}, data_w[g][p], ed);
         check_vec({tag, "_ovfl"}, ovfl_w[g][p], eo);
         check_vec({tag, "_other_valid"}, valid_w[g][1-p], 0);
      end
      step();
      for (int g = 0; g < 2; g++) check_vec({tag, "_drop"}, valid_w[g][p], 0);
   endtask

   initial begin
      rst_n = 1'b0; rsp_ready = 2'b11; req_valid = 2'b11;
      req_a[0] = 16'h0003; req_b[0] = 16'h0004; req_sub[0] = 1'b0;
      req_a[1] = 16'h1111; req_b[1] = 16'h0001; req_sub[1] = 1'b0;

      // Reset held with both requesting.
      for (int i = 0; i < 2; i++) begin
         step();
         for (int g = 0; g < 2; g++) begin
            check_vec("rst_ready", ready_w[g], 0);
            check_vec("rst_valid", valid_w[g], 0);
            check_vec("rst_data0", data_w[g][0], 0);
            check_vec("rst_au_a", au_a_w[g], 0);
         end
      end
      rst_n = 1'b1;
      #1;
      for (int g = 0; g < 2; g++) check_vec("first_grant", ready_w[g], 2'b01);
      step();
      req_valid = 2'b00;
      check_vec("exec_valid", valid_w[0][0], 0);
      check_vec("exec_au_a", au_a_w[0], 16'h0003);
      check_vec("exec_au_b", au_b_w[0], 16'h0004);
      step();
      for (int g = 0; g < 2; g++) begin
         check_vec("add_valid", valid_w[g][0], 1);
         check_vec("add_data", data_w[g][0], 16'h0007);
         check_vec("add_ovfl", ovfl_w[g][0], 0);
         check_vec("add_p1_valid", valid_w[g][1], 0);
      end
      step();
      check_vec("add_drop", valid_w[0][0], 0);

      do_req(1, 16'h7000, 16'h2000, 1'b0, 16'h7FFF, 1'b1, "sat_pos");
      do_req(1, 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, "sat_neg");
      do_req(0, 16'hFFFE, 16'h0005, 1'b1, 16'hFFF9, 1'b0, "sub_neg");

      // Contention: both valid, responses always taken.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req_a[0] = 16'h0001; req_b[0] = 16'h0002; req_sub[0] = 1'b0;
      req_a[1] = 16'h000A; req_b[1] = 16'h0005; req_sub[1] = 1'b1;
      req_valid = 2'b11;
      #1;
      for (int k = 0; k < 12; k++) begin
         for (int g = 0; g < 2; g++) begin
            int ep;
            ep = (g == 0) ? ((k / 3) % 2) : 0;
            check_vec($sformatf("cont%0d_k%0d_rdy0", g, k), ready_w[g][0],
                      ((k % 3 == 0) && ep == 0) ? 1 : 0);
            check_vec($sformatf("cont%0d_k%0d_rdy1", g, k), ready_w[g][1],
                      ((k % 3 == 0) && ep == 1) ? 1 : 0);
            check_vec($sformatf("cont%0d_k%0d_vld", g, k), valid_w[g][ep],
                      (k % 3 == 2) ? 1 : 0);
            check_vec($sformatf("cont%0d_k%0d_vld_o", g, k), valid_w[g][1-ep], 0);
            if (k % 3 == 2)
               check_vec($sformatf("cont%0d_k%0d_data", g, k), data_w[g][ep],
                         (ep == 1) ? 16'h0005 : 16'h0003);
         end
         step();
      end

      // Backpressure on port 0 with port 1 waiting.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; rsp_ready[0] = 1'b0;
      #1;
      check_vec("bp_grant0", ready_w[0], 2'b01);
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         for (int g = 0; g < 2; g++) begin
            check_vec($sformatf("bp%0d_hold_valid_%0d", g, i), valid_w[g][0], 1);
            check_vec($sformatf("bp%0d_hold_data_%0d", g, i), data_w[g][0], 16'h0003);
            check_vec($sformatf("bp%0d_no_ready_%0d", g, i), ready_w[g], 0);
         end
         if (i < 4) step();
      end
      rsp_ready[0] = 1'b1;
      step();
      check_vec("bp_release_valid", valid_w[0][0], 0);
      check_vec("bp_grant1_rr", ready_w[0], 2'b10);
      check_vec("bp_grant0_fp", ready_w[1], 2'b01);
      step();
      step();
      check_vec("bp_p1_valid", valid_w[0][1], 1);
      check_vec("bp_p1_data", data_w[0][1], 16'h0005);
      check_vec("bp_fp_p0_data", data_w[1][0], 16'h0003);
      req_valid = 2'b00;
      step();

      // Reset during EXEC drops the transaction.
      req_a[0] = 16'h0100; req_b[0] = 16'h0200; req_sub[0] = 1'b0; req_valid[0] = 1'b1;
      #1;
      check_vec("mid_ready", ready_w[0][0], 1);
      step();
      rst_n = 1'b0; req_valid[0] = 1'b0;
      step();
      for (int g = 0; g < 2; g++) begin
         check_vec("mid_rst_valid", valid_w[g], 0);
         check_vec("mid_rst_au_a", au_a_w[g], 0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         for (int g = 0; g < 2; g++) check_vec($sformatf("mid_no_rsp_%0d", i), valid_w[g], 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
